fifo_protocol_monitor: RTL and testbench

FIFO_PROTOCOL_MONITOR -- requirements
Module: fifo_protocol_monitor

---
 rtl/fifo_protocol_monitor_if.sv | 30 +++
 rtl/fifo_protocol_monitor.sv | 178 +++++++++++++++++
 tb/tb_fifo_protocol_monitor.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_protocol_monitor_if.sv
// Observation bundle between a FIFO and its protocol monitor.
// master drives the FIFO-side signals, slave only observes them.
interface fifo_protocol_monitor_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;

  modport master (
    output wr_en,
    output wr_data,
    output full,
    output rd_en,
    output rd_data,
    output empty
  );

  modport slave (
    input wr_en,
    input wr_data,
    input full,
    input rd_en,
    input rd_data,
    input empty
  );
endinterface

// File: rtl/fifo_protocol_monitor.sv
// Shadow-tracks FIFO fill level and flags, counts events, sticky errors.
// Define FIFO_MON_DATA_CHECK_EN to add shadow-memory data checking.
module fifo_protocol_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_protocol_monitor_if.slave fifo,
  input  logic                  clr,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic [1:0]            mon_state,
  output logic                  err_full_flag,
  output logic                  err_empty_flag,
  output logic                  err_full_and_empty,
  output logic                  err_data,
  output logic                  err_any,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_rej_count,
  output logic [CNT_WIDTH-1:0]  rd_rej_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  function automatic logic [CNT_WIDTH-1:0] bump(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 en,
    input logic                 cl
  );
    if (cl) return '0;
    if (en && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  logic                 wa;
  logic                 ra;
  logic [ADDR_WIDTH:0]  occ_q, occ_d;
  state_e               state_q, state_d;
  logic                 err_full_q, err_full_d;
  logic                 err_empty_q, err_empty_d;
  logic                 err_fe_q, err_fe_d;
  logic                 err_data_q, err_data_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0] wrj_cnt_q, wrj_cnt_d;
  logic [CNT_WIDTH-1:0] rrj_cnt_q, rrj_cnt_d;
  logic                 any_err_d;

  always_comb begin
    wa    = fifo.wr_en && !fifo.full;
    ra    = fifo.rd_en && !fifo.empty;
    occ_d = occ_q;
    // Guards keep the shadow sane even if the DUT lies about its flags.
    if (wa && !ra && (occ_q != DEPTH_C)) begin
      occ_d = occ_q + 1'b1;
    end else if (ra && !wa && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end

    err_full_d  = (err_full_q && !clr) ||
                  (fifo.full != (occ_q == DEPTH_C));
    err_empty_d = (err_empty_q && !clr) ||
                  (fifo.empty != (occ_q == '0));
    err_fe_d    = (err_fe_q && !clr) ||
                  (fifo.full && fifo.empty);

    wr_cnt_d  = bump(wr_cnt_q, wa, clr);
    rd_cnt_d  = bump(rd_cnt_q, ra, clr);
    wrj_cnt_d = bump(wrj_cnt_q, fifo.wr_en && fifo.full, clr);
    rrj_cnt_d = bump(rrj_cnt_q, fifo.rd_en && fifo.empty, clr);
  end

  always_comb begin
    any_err_d = err_full_d | err_empty_d | err_fe_d | err_data_d;
    if (any_err_d) begin
      state_d = ST_ERROR;
    end else if (occ_d == '0) begin
      state_d = ST_EMPTY;
    end else if (occ_d == DEPTH_C) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= '0;
      state_q     <= ST_EMPTY;
      err_full_q  <= 1'b0;
      err_empty_q <= 1'b0;
      err_fe_q    <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wrj_cnt_q   <= '0;
      rrj_cnt_q   <= '0;
    end else begin
      occ_q       <= occ_d;
      state_q     <= state_d;
      err_full_q  <= err_full_d;
      err_empty_q <= err_empty_d;
      err_fe_q    <= err_fe_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wrj_cnt_q   <= wrj_cnt_d;
      rrj_cnt_q   <= rrj_cnt_d;
    end
  end

`ifdef FIFO_MON_DATA_CHECK_EN
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;

  // rd_data lags the accepted read by one cycle, so latch the expectation.
  always_comb begin
    wr_ptr_d   = wa ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = ra ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pend_d     = ra;
    exp_d      = ra ? mem_q[rd_ptr_q] : exp_q;
    err_data_d = (err_data_q && !clr) ||
                 (pend_q && (fifo.rd_data != exp_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= 1'b0;
      exp_q      <= '0;
      err_data_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      exp_q      <= exp_d;
      err_data_q <= err_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wa) begin
      mem_q[wr_ptr_q] <= fifo.wr_data;
    end
  end
`else
  assign err_data_d = 1'b0;
  assign err_data_q = 1'b0;
`endif

  assign occupancy          = occ_q;
  assign mon_state          = state_q;
  assign err_full_flag      = err_full_q;
  assign err_empty_flag     = err_empty_q;
  assign err_full_and_empty = err_fe_q;
  assign err_data           = err_data_q;
  assign err_any            = err_full_q | err_empty_q |
                              err_fe_q | err_data_q;
  assign wr_count           = wr_cnt_q;
  assign rd_count           = rd_cnt_q;
  assign wr_rej_count       = wrj_cnt_q;
  assign rd_rej_count       = rrj_cnt_q;

endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// Directed bench for fifo_protocol_monitor: a reference FIFO queue drives
// truthful flags and read data; vector table plus hand-written sequences.
module tb_fifo_protocol_monitor;

`ifdef FIFO_MON_DATA_CHECK_EN
  localparam int ED = 1;
`else
  localparam int ED = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [4:0] occupancy;
  logic [1:0] mon_state;
  logic       err_full_flag;
  logic       err_empty_flag;
  logic       err_full_and_empty;
  logic       err_data;
  logic       err_any;
  logic [4:0] wr_count;
  logic [4:0] rd_count;
  logic [4:0] wr_rej_count;
  logic [4:0] rd_rej_count;

  fifo_protocol_monitor_if #(.DATA_WIDTH(8)) bus ();

  fifo_protocol_monitor #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .CNT_WIDTH (5)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fifo              (bus.slave),
    .clr               (clr),
    .occupancy         (occupancy),
    .mon_state         (mon_state),
    .err_full_flag     (err_full_flag),
    .err_empty_flag    (err_empty_flag),
    .err_full_and_empty(err_full_and_empty),
    .err_data          (err_data),
    .err_any           (err_any),
    .wr_count          (wr_count),
    .rd_count          (rd_count),
    .wr_rej_count      (wr_rej_count),
    .rd_rej_count      (rd_rej_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q[$];

  typedef struct {
    logic we, re, fl, em, cl;
    int   occ, st;
    logic ff, ef, fe;
    int   wc, rc, wrj, rrj;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock of stimulus; the queue models the real FIFO behind the flags.
  task automatic cyc(input logic we, input logic [7:0] wd,
                     input logic re, input logic fl,
                     input logic em, input logic cl);
    logic wa, ra;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.full    = fl;
    bus.empty   = em;
    clr         = cl;
    wa = we && !fl;
    ra = re && !em;
    @(posedge clk);
    #1;
    if (ra && q.size() > 0) bus.rd_data = q.pop_front();
    if (wa) q.push_back(wd);
  endtask

  task automatic go(input logic we, input logic [7:0] wd,
                    input logic re, input logic cl);
    cyc(we, wd, re, q.size() == 16, q.size() == 0, cl);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en = 1'b0;
    bus.rd_data = 8'h00;
    bus.full = 1'b0;
    bus.empty = 1'b1;

    tbl[0] = '{1,0,0,0,0, 9,1, 0,0,0, 1,0,0,0};
    tbl[1] = '{0,1,0,0,0, 8,1, 0,0,0, 1,1,0,0};
    tbl[2] = '{0,0,1,0,0, 8,3, 1,0,0, 1,1,0,0};
    tbl[3] = '{0,0,0,0,0, 8,3, 1,0,0, 1,1,0,0};
    tbl[4] = '{0,0,0,0,1, 8,1, 0,0,0, 0,0,0,0};
    tbl[5] = '{1,1,1,1,0, 8,3, 1,1,1, 0,0,1,1};
    tbl[6] = '{0,0,1,0,1, 8,3, 1,0,0, 0,0,0,0};
    tbl[7] = '{0,0,0,0,1, 8,1, 0,0,0, 0,0,0,0};

    #22;
    chk("rst_occ", occupancy, 0);
    chk("rst_state", mon_state, 0);
    chk("rst_err_any", err_any, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rrj_count", rd_rej_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) go(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_occ", occupancy, 16);
    chk("fill_state", mon_state, 2);
    chk("fill_wr_count", wr_count, 16);
    chk("fill_err_any", err_any, 0);

    for (int i = 0; i < 3; i++) go(1'b1, 8'hEE, 1'b0, 1'b0);
    go(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rej_wrj_count", wr_rej_count, 3);
    chk("rej_occ", occupancy, 16);
    chk("rej_wr_count", wr_count, 16);
    chk("rej_err_any", err_any, 0);
    chk("rej_state", mon_state, 2);

    for (int i = 0; i < 11; i++) go(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_occ", occupancy, 5);
    chk("drain_rd_count", rd_count, 11);
    chk("drain_state", mon_state, 1);

    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fe_err_empty", err_empty_flag, 1);
    chk("fe_err_fae", err_full_and_empty, 0);
    chk("fe_err_full", err_full_flag, 0);
    chk("fe_state", mon_state, 3);
    chk("fe_err_any", err_any, 1);
    go(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fe_sticky", err_empty_flag, 1);
    chk("fe_sticky_state", mon_state, 3);
    go(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_err_empty", err_empty_flag, 0);
    chk("clr_err_any", err_any, 0);
    chk("clr_wr_count", wr_count, 0);
    chk("clr_rd_count", rd_count, 0);
    chk("clr_wrj_count", wr_rej_count, 0);
    chk("clr_state", mon_state, 1);
    chk("clr_occ", occupancy, 5);

    for (int i = 0; i < 3; i++) go(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) go(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
    go(1'b0, 8'h00, 1'b0, 1'b0);
    chk("sim_occ", occupancy, 8);
    chk("sim_wr_count", wr_count, 23);
    chk("sim_rd_count", rd_count, 20);
    chk("sim_err_any", err_any, 0);
    chk("sim_state", mon_state, 1);
    go(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].we, 8'h30 + 8'(i), tbl[i].re,
          tbl[i].fl, tbl[i].em, tbl[i].cl);
      chk($sformatf("v%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("v%0d_state", i), mon_state, tbl[i].st);
      chk($sformatf("v%0d_ff", i), err_full_flag, tbl[i].ff);
      chk($sformatf("v%0d_ef", i), err_empty_flag, tbl[i].ef);
      chk($sformatf("v%0d_fe", i), err_full_and_empty, tbl[i].fe);
      chk($sformatf("v%0d_wc", i), wr_count, tbl[i].wc);
      chk($sformatf("v%0d_rc", i), rd_count, tbl[i].rc);
      chk($sformatf("v%0d_wrj", i), wr_rej_count, tbl[i].wrj);
      chk($sformatf("v%0d_rrj", i), rd_rej_count, tbl[i].rrj);
    end

    for (int i = 0; i < 35; i++) go(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
    go(1'b0, 8'h00, 1'b0, 1'b0);
    chk("sat_wr_count", wr_count, 31);
    chk("sat_rd_count", rd_count, 31);
    chk("sat_occ", occupancy, 8);
    chk("sat_err_any", err_any, 0);

    for (int i = 0; i < 8; i++) go(1'b0, 8'h00, 1'b1, 1'b0);
    go(1'b1, 8'hA5, 1'b0, 1'b0);
    go(1'b0, 8'h00, 1'b1, 1'b0);
    bus.rd_data = 8'h5A;
    go(1'b0, 8'h00, 1'b0, 1'b0);
    chk("data_err_data", err_data, ED);
    chk("data_err_any", err_any, ED);
    chk("data_state", mon_state, ED ? 3 : 0);
    chk("data_occ", occupancy, 0);
    go(1'b0, 8'h00, 1'b0, 1'b1);
    chk("data_clr", err_any, 0);

    for (int i = 0; i < 7; i++) go(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    chk("burst_occ", occupancy, 7);
    chk("burst_wr_count", wr_count, 7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_state", mon_state, 0);
    chk("arst_wr_count", wr_count, 0);
    chk("arst_err_any", err_any, 0);
    q.delete();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.full = 1'b0;
    bus.empty = 1'b1;
    bus.rd_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    go(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_occ", occupancy, 0);
    chk("post_state", mon_state, 0);
    chk("post_err_any", err_any, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
